// File: rtl/oled_price_sequencer.sv
// Price/coin readout sequencer: latches three cent values, converts them to BCD
// serially, then streams 3 rows of "D.TU" characters. Optional macro: LEADING_BLANK_EN.
module oled_price_sequencer #(
   parameter int         COL_START = 4,
   parameter logic [7:0] DP_CHAR   = 8'h2E
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] coins,
   input  logic [7:0] cost,
   input  logic [7:0] tot,
   input  logic       update,
   output logic       char_valid,
   input  logic       char_ready,
   output logic [7:0] char_data,
   output logic [1:0] char_row,
   output logic [3:0] char_col,
   output logic       busy,
   output logic       frame_done
);

   typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

   localparam logic [3:0] COL_BASE    = 4'(COL_START);
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   state_t      state_reg;
   logic        valid_reg;
   logic        busy_reg;
   logic        frame_done_reg;
   logic [7:0]  data_reg;
   logic [1:0]  row_reg;
   logic [1:0]  pos_reg;
   logic [3:0]  col_reg;
   logic        pending_reg;
   logic [2:0]  cnt_reg;
   logic [7:0]  val_reg [3];
   logic [9:0]  bcd_reg [3];

   logic [7:0]  in_vals  [3];
   logic [9:0]  bcd_step [3];
   logic        last_char;
   logic        start_frame;
   logic [1:0]  next_pos;
   logic [1:0]  next_row;
   logic [9:0]  next_bcd;

   assign in_vals[0] = coins;
   assign in_vals[1] = cost;
   assign in_vals[2] = tot;

   // One shift-add-3 step per field; the hundreds pair never reaches 5 so it needs no adjust.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dabble
         logic [3:0] units_adj;
         logic [3:0] tens_adj;
         assign units_adj = (bcd_reg[gi][3:0] >= 4'd5) ? bcd_reg[gi][3:0] + 4'd3 : bcd_reg[gi][3:0];
         assign tens_adj  = (bcd_reg[gi][7:4] >= 4'd5) ? bcd_reg[gi][7:4] + 4'd3 : bcd_reg[gi][7:4];
         assign bcd_step[gi] = {bcd_reg[gi][8], tens_adj, units_adj, val_reg[gi][7]};
      end
   endgenerate

   function automatic logic [7:0] field_char(input logic [9:0] bcd, input logic [1:0] pos);
      logic [7:0] c;
      case (pos)
         2'd0: begin
            c = ASCII_ZERO + {6'd0, bcd[9:8]};
`ifdef LEADING_BLANK_EN
            if (bcd[9:8] == 2'd0) c = ASCII_SPACE;
`endif
         end
         2'd1:    c = DP_CHAR;
         2'd2:    c = ASCII_ZERO + {4'd0, bcd[7:4]};
         default: c = ASCII_ZERO + {4'd0, bcd[3:0]};
      endcase
      return c;
   endfunction

   assign last_char = (row_reg == 2'd2) && (pos_reg == 2'd3);
   assign next_pos  = pos_reg + 2'd1;
   assign next_row  = (pos_reg == 2'd3) ? row_reg + 2'd1 : row_reg;

   // A new frame starts from IDLE, or back-to-back when a request arrived during the frame.
   assign start_frame = ((state_reg == IDLE) && update) ||
                        ((state_reg == SEND) && char_ready && last_char && (pending_reg || update));

   always_comb begin
      next_bcd = bcd_reg[2];
      case (next_row)
         2'd0:    next_bcd = bcd_reg[0];
         2'd1:    next_bcd = bcd_reg[1];
         default: next_bcd = bcd_reg[2];
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         valid_reg      <= 1'b0;
         busy_reg       <= 1'b0;
         frame_done_reg <= 1'b0;
         data_reg       <= ASCII_SPACE;
         row_reg        <= 2'd0;
         pos_reg        <= 2'd0;
         col_reg        <= COL_BASE;
         pending_reg    <= 1'b0;
         cnt_reg        <= 3'd0;
         for (int i = 0; i < 3; i++) begin
            bcd_reg[i] <= '0;
            val_reg[i] <= '0;
         end
      end else begin
         frame_done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (update) begin
                  state_reg <= CONV;
                  busy_reg  <= 1'b1;
               end
            end
            CONV: begin
               if (update) pending_reg <= 1'b1;
               for (int i = 0; i < 3; i++) begin
                  bcd_reg[i] <= bcd_step[i];
                  val_reg[i] <= {val_reg[i][6:0], 1'b0};
               end
               cnt_reg <= cnt_reg + 3'd1;
               if (cnt_reg == 3'd7) begin
                  // First character is built from the final step so valid and data rise together.
                  state_reg <= SEND;
                  valid_reg <= 1'b1;
                  row_reg   <= 2'd0;
                  pos_reg   <= 2'd0;
                  col_reg   <= COL_BASE;
                  data_reg  <= field_char(bcd_step[0], 2'd0);
               end
            end
            SEND: begin
               if (update) pending_reg <= 1'b1;
               if (char_ready) begin
                  if (last_char) begin
                     valid_reg      <= 1'b0;
                     frame_done_reg <= 1'b1;
                     row_reg        <= 2'd0;
                     pos_reg        <= 2'd0;
                     col_reg        <= COL_BASE;
                     data_reg       <= ASCII_SPACE;
                     if (pending_reg || update) begin
                        state_reg   <= CONV;
                        pending_reg <= 1'b0;
                     end else begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                     end
                  end else begin
                     row_reg  <= next_row;
                     pos_reg  <= next_pos;
                     col_reg  <= COL_BASE + {2'd0, next_pos};
                     data_reg <= field_char(next_bcd, next_pos);
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
         if (start_frame) begin
            for (int i = 0; i < 3; i++) begin
               val_reg[i] <= in_vals[i];
               bcd_reg[i] <= '0;
            end
            cnt_reg <= 3'd0;
         end
      end
   end

   assign char_valid = valid_reg;
   assign char_data  = data_reg;
   assign char_row   = row_reg;
   assign char_col   = col_reg;
   assign busy       = busy_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_oled_price_sequencer.sv
// Self-checking bench for oled_price_sequencer: table-driven frames plus hand-written
// pending and mid-frame reset sequences, all checked through an expected-character queue.
module tb_oled_price_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] coins, cost, tot;
   logic       update;
   logic       char_valid;
   logic       char_ready;
   logic [7:0] char_data;
   logic [1:0] char_row;
   logic [3:0] char_col;
   logic       busy;
   logic       frame_done;

   oled_price_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .coins      (coins),
      .cost       (cost),
      .tot        (tot),
      .update     (update),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .char_data  (char_data),
      .char_row   (char_row),
      .char_col   (char_col),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] row;
      logic [3:0] col;
      logic [7:0] data;
   } xfer_t;

   typedef struct {
      logic [7:0]  coins;
      logic [7:0]  cost;
      logic [7:0]  tot;
      bit          stall;
      logic [31:0] r0;
      logic [31:0] r1;
      logic [31:0] r2;
   } vec_t;

   xfer_t exp_q [$];
   vec_t  vecs [4];

   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   bit    stall_mode = 0;
   int    frame_xfers = 0;
   int    frames_done = 0;
   int    fd_cyc = 0;
   int    rise_cyc = 0;
   int    upd_cyc = 0;
   bit    have_held = 0;
   bit    prev_valid = 0;
   xfer_t held;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Ready generator: 1,0,0,1 pattern while stalling, otherwise always ready.
   initial begin
      char_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (stall_mode) char_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         else            char_ready = 1'b1;
      end
   end

   // Monitor: samples mid-cycle, pops the scoreboard on each transfer.
   always @(negedge clk) begin
      if (!rst_n) begin
         frame_xfers = 0;
         have_held   = 1'b0;
         prev_valid  = 1'b0;
      end else begin
         if (have_held) begin
            chk("stall_valid", {31'd0, char_valid}, 32'd1);
            chk("stall_hold", {18'd0, char_row, char_col, char_data}, {18'd0, held});
         end
         have_held = char_valid && !char_ready;
         held      = {char_row, char_col, char_data};
         if (char_valid && !prev_valid) rise_cyc = cyc;
         prev_valid = char_valid;
         if (char_valid && char_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_xfer actual=%h required=none (cycle %0d)",
                        {char_row, char_col, char_data}, cyc);
            end else begin
               xfer_t e;
               e = exp_q.pop_front();
               chk("char", {18'd0, char_row, char_col, char_data}, {18'd0, e});
               $display("xfer row=%0d col=%0d data=%h", char_row, char_col, char_data);
            end
            frame_xfers++;
         end
         if (frame_done) begin
            chk("fd_count", frame_xfers, 12);
            chk("fd_valid_low", {31'd0, char_valid}, 32'd0);
            $display("frame_done after %0d transfers at cycle %0d", frame_xfers, cyc);
            frames_done++;
            fd_cyc = cyc;
            frame_xfers = 0;
         end
      end
   end

   task automatic push_frame(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2);
      logic [31:0] w;
      logic [7:0]  b;
      for (int r = 0; r < 3; r++) begin
         w = (r == 0) ? r0 : (r == 1) ? r1 : r2;
         for (int p = 0; p < 4; p++) begin
            b = w[31 - 8*p -: 8];
`ifdef LEADING_BLANK_EN
            if (p == 0 && b == 8'h30) b = 8'h20;
`endif
            exp_q.push_back({2'(r), 4'(4 + p), b});
         end
      end
   endtask

   task automatic pulse_update(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
      @(posedge clk);
      #2;
      coins = c0; cost = c1; tot = c2;
      update = 1'b1;
      upd_cyc = cyc;
      @(posedge clk);
      #2;
      update = 1'b0;
   endtask

   task automatic wait_fd(input int target, input int budget);
      int n;
      n = 0;
      while (frames_done < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk("fd_timeout", {31'd0, frames_done >= target}, 32'd1);
   endtask

   initial begin
      int fd_base;
      int fd1;
      int n;

      vecs[0] = '{8'd75,  8'd125, 8'd50,  1'b0, "0.75", "1.25", "0.50"};
      vecs[1] = '{8'd255, 8'd0,   8'd100, 1'b1, "2.55", "0.00", "1.00"};
      vecs[2] = '{8'd5,   8'd99,  8'd200, 1'b0, "0.05", "0.99", "2.00"};
      vecs[3] = '{8'd10,  8'd20,  8'd30,  1'b1, "0.10", "0.20", "0.30"};

      // Reset held with update high: outputs stay idle.
      rst_n = 1'b0; update = 1'b1; coins = 8'd1; cost = 8'd2; tot = 8'd3;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_valid", {31'd0, char_valid}, 32'd0);
         chk("rst_busy", {31'd0, busy}, 32'd0);
         chk("rst_fd", {31'd0, frame_done}, 32'd0);
      end
      chk("rst_data", {24'd0, char_data}, 32'h20);
      chk("rst_col", {28'd0, char_col}, 32'd4);
      chk("rst_row", {30'd0, char_row}, 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1; update = 1'b0;
      repeat (2) @(posedge clk);

      // Table-driven frames.
      for (int v = 0; v < 4; v++) begin
         stall_mode = vecs[v].stall;
         fd_base = frames_done;
         push_frame(vecs[v].r0, vecs[v].r1, vecs[v].r2);
         $display("frame %0d: %0d/%0d/%0d stall=%0d", v, vecs[v].coins, vecs[v].cost, vecs[v].tot, vecs[v].stall);
         pulse_update(vecs[v].coins, vecs[v].cost, vecs[v].tot);
         @(negedge clk);
         chk("busy_conv", {31'd0, busy}, 32'd1);
         wait_fd(fd_base + 1, 400);
         chk("rise_latency", rise_cyc - upd_cyc, 9);
         if (!vecs[v].stall) chk("fd_latency", fd_cyc - upd_cyc, 21);
         stall_mode = 1'b0;
         repeat (2) @(posedge clk);
         #2;
         chk("busy_idle", {31'd0, busy}, 32'd0);
      end

      // Second request mid-frame with changed inputs: queued, then back-to-back frame.
      fd_base = frames_done;
      push_frame("0.75", "1.25", "0.50");
      pulse_update(8'd75, 8'd125, 8'd50);
      n = 0;
      while (frame_xfers < 3 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #2;
      coins = 8'd10; cost = 8'd20; tot = 8'd30;
      push_frame("0.10", "0.20", "0.30");
      update = 1'b1;
      @(posedge clk);
      #2;
      update = 1'b0;
      wait_fd(fd_base + 1, 400);
      fd1 = fd_cyc;
      chk("busy_between", {31'd0, busy}, 32'd1);
      wait_fd(fd_base + 2, 400);
      chk("b2b_gap", rise_cyc - fd1, 8);
      repeat (2) @(posedge clk);

      // Reset after the 5th transfer: frame abandoned, then a fresh frame.
      fd_base = frames_done;
      push_frame("2.55", "0.00", "1.00");
      pulse_update(8'd255, 8'd0, 8'd100);
      n = 0;
      while (frame_xfers < 5 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      chk("midrst_valid", {31'd0, char_valid}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_fd", {31'd0, frame_done}, 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      chk("midrst_no_fd", frames_done, fd_base);
      push_frame("0.10", "0.20", "0.30");
      pulse_update(8'd10, 8'd20, 8'd30);
      wait_fd(fd_base + 1, 400);
      repeat (3) @(posedge clk);

      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
